// File: rtl/phase_measure_pkg.sv
// ---------------------------------------------------------------------------
// phase_measure_pkg
// Shared definitions for the phase measurement block: the measurement FSM
// state encoding and the default sample width, counter width, crossing
// threshold, re-arm hysteresis and timeout constants.
// ---------------------------------------------------------------------------
package phase_measure_pkg;

   // Lag measurement FSM: waiting for a reference crossing, or counting
   // samples until the shifted stream crosses.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_t;

   localparam int DEF_DW      = 12;
   localparam int DEF_CW      = 10;
   localparam int DEF_MID     = 2048;
   localparam int DEF_HYST    = 64;
   localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/xing_detect.sv
// ---------------------------------------------------------------------------
// xing_detect
// Rising mid-scale crossing detector with re-arm hysteresis for one sample
// stream. A crossing is flagged combinationally on the valid sample that
// first reaches MID after the previous sample was below MID, provided the
// detector has been armed by some earlier sample below MID-HYST. A detected
// crossing disarms the detector, so dither around MID is counted once.
//
// Ports:
//    i_clk       system clock
//    i_rst_n     synchronous active-low reset (disarms, clears history)
//    i_in_valid  sample strobe; history only advances when high
//    i_sample    unsigned DW-bit sample
//    o_xing      crossing detected on the current valid sample
// ---------------------------------------------------------------------------
module xing_detect
   import phase_measure_pkg::*;
#(
   parameter int DW   = DEF_DW,
   parameter int MID  = DEF_MID,
   parameter int HYST = DEF_HYST
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_in_valid,
   input  logic [DW-1:0] i_sample,
   output logic          o_xing
);

   localparam logic [DW-1:0] MID_V = DW'(MID);
   localparam logic [DW-1:0] ARM_V = DW'(MID - HYST);

   logic [DW-1:0] r_prev;
   logic          r_armed;
   logic          w_xing;

   assign w_xing = i_in_valid && r_armed && (r_prev < MID_V) && (i_sample >= MID_V);
   assign o_xing = w_xing;

   // Previous-sample history and arming flag. A crossing sample is always
   // >= MID, so it can never re-arm on the same sample it disarms.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_prev  <= '0;
         r_armed <= 1'b0;
      end else if (i_in_valid) begin
         r_prev <= i_sample;
         if (w_xing) begin
            r_armed <= 1'b0;
         end else if (i_sample < ARM_V) begin
            r_armed <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/phase_measure.sv
// ---------------------------------------------------------------------------
// phase_measure
// Measures the lag, in samples, of a phase-shifted sine stream behind its
// reference stream, plus the reference period, using rising mid-scale
// crossings. Results and pulses are registered and appear the clock after
// the valid sample that produced them.
//
// Ports:
//    i_clk            system clock
//    i_rst_n          synchronous active-low reset
//    i_in_valid       sample strobe for both streams
//    i_ref_in         reference sine sample
//    i_shf_in         phase-shifted sine sample
//    o_phase          lag modulo 256 (low byte of o_delay)
//    o_delay          raw lag count
//    o_period         samples between the last two reference crossings
//    o_phase_valid    one-cycle pulse: o_phase/o_delay updated
//    o_period_valid   one-cycle pulse: o_period updated
//    o_timeout        one-cycle pulse: a measurement was abandoned
// ---------------------------------------------------------------------------
module phase_measure
   import phase_measure_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int CW      = DEF_CW,
   parameter int MID     = DEF_MID,
   parameter int HYST    = DEF_HYST,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_in_valid,
   input  logic [DW-1:0] i_ref_in,
   input  logic [DW-1:0] i_shf_in,
   output logic [7:0]    o_phase,
   output logic [CW-1:0] o_delay,
   output logic [CW-1:0] o_period,
   output logic          o_phase_valid,
   output logic          o_period_valid,
   output logic          o_timeout
);

   localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

   logic          w_ref_xing;
   logic          w_shf_xing;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_delay_cnt;
   logic [CW-1:0] w_delay_cnt_nxt;
   logic [CW-1:0] w_delay_inc;
   logic [CW-1:0] r_delay;
   logic [CW-1:0] w_delay_nxt;
   logic          r_phase_valid;
   logic          w_phase_valid_nxt;
   logic          w_meas_timeout;

   logic          r_per_run;
   logic          w_per_run_nxt;
   logic          r_per_sat;
   logic          w_per_sat_nxt;
   logic [CW-1:0] r_per_cnt;
   logic [CW-1:0] w_per_cnt_nxt;
   logic [CW-1:0] w_per_inc;
   logic [CW-1:0] r_period;
   logic [CW-1:0] w_period_nxt;
   logic          r_period_valid;
   logic          w_period_valid_nxt;
   logic          w_per_timeout;

   logic          r_timeout;

   xing_detect #(
      .DW   (DW),
      .MID  (MID),
      .HYST (HYST)
   ) u_ref_xing (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_in_valid (i_in_valid),
      .i_sample   (i_ref_in),
      .o_xing     (w_ref_xing)
   );

   xing_detect #(
      .DW   (DW),
      .MID  (MID),
      .HYST (HYST)
   ) u_shf_xing (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_in_valid (i_in_valid),
      .i_sample   (i_shf_in),
      .o_xing     (w_shf_xing)
   );

   // delay_cnt holds (samples since ref crossing - 1), so the lag reported
   // on a shf crossing is delay_cnt + 1.
   assign w_delay_inc = r_delay_cnt + CW'(1);
   assign w_per_inc   = r_per_cnt + CW'(1);

   // Lag measurement next-state logic. A coincident ref crossing in COUNT
   // both closes the running measurement and starts the next one.
   always_comb begin
      w_state_nxt       = r_state;
      w_delay_cnt_nxt   = r_delay_cnt;
      w_delay_nxt       = r_delay;
      w_phase_valid_nxt = 1'b0;
      w_meas_timeout    = 1'b0;
      if (i_in_valid) begin
         case (r_state)
            ST_IDLE: begin
               if (w_ref_xing) begin
                  w_delay_cnt_nxt = '0;
                  if (w_shf_xing) begin
                     w_delay_nxt       = '0;
                     w_phase_valid_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_COUNT;
                  end
               end
            end
            ST_COUNT: begin
               if (w_shf_xing) begin
                  w_delay_nxt       = w_delay_inc;
                  w_phase_valid_nxt = 1'b1;
                  if (w_ref_xing) begin
                     w_delay_cnt_nxt = '0;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else if (w_ref_xing) begin
                  w_delay_cnt_nxt = '0;
               end else if (w_delay_inc == TO_V) begin
                  w_meas_timeout  = 1'b1;
                  w_delay_cnt_nxt = '0;
                  w_state_nxt     = ST_IDLE;
               end else begin
                  w_delay_cnt_nxt = w_delay_inc;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Reference period next-state logic. The counter starts at the first
   // ref crossing; after saturating it stays frozen until the next crossing,
   // which restarts it without reporting the overlong period.
   always_comb begin
      w_per_run_nxt      = r_per_run;
      w_per_sat_nxt      = r_per_sat;
      w_per_cnt_nxt      = r_per_cnt;
      w_period_nxt       = r_period;
      w_period_valid_nxt = 1'b0;
      w_per_timeout      = 1'b0;
      if (i_in_valid) begin
         if (w_ref_xing) begin
            if (r_per_run && !r_per_sat) begin
               w_period_nxt       = w_per_inc;
               w_period_valid_nxt = 1'b1;
            end
            w_per_run_nxt = 1'b1;
            w_per_sat_nxt = 1'b0;
            w_per_cnt_nxt = '0;
         end else if (r_per_run && !r_per_sat) begin
            if (w_per_inc == TO_V) begin
               w_per_sat_nxt = 1'b1;
               w_per_timeout = 1'b1;
            end else begin
               w_per_cnt_nxt = w_per_inc;
            end
         end
      end
   end

   // State, counters and registered results. Both abandon paths share one
   // timeout pulse.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_delay_cnt    <= '0;
         r_delay        <= '0;
         r_phase_valid  <= 1'b0;
         r_per_run      <= 1'b0;
         r_per_sat      <= 1'b0;
         r_per_cnt      <= '0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_timeout      <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_delay_cnt    <= w_delay_cnt_nxt;
         r_delay        <= w_delay_nxt;
         r_phase_valid  <= w_phase_valid_nxt;
         r_per_run      <= w_per_run_nxt;
         r_per_sat      <= w_per_sat_nxt;
         r_per_cnt      <= w_per_cnt_nxt;
         r_period       <= w_period_nxt;
         r_period_valid <= w_period_valid_nxt;
         r_timeout      <= w_meas_timeout | w_per_timeout;
      end
   end

   assign o_phase        = r_delay[7:0];
   assign o_delay        = r_delay;
   assign o_period       = r_period;
   assign o_phase_valid  = r_phase_valid;
   assign o_period_valid = r_period_valid;
   assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_phase_measure.sv
// ---------------------------------------------------------------------------
// tb_phase_measure
// Self-checking bench for phase_measure: a directed vector table for the
// crossing/hysteresis/FSM corners, then sine-stream scenarios checked every
// clock against a behavioural model built from sample indices.
// ---------------------------------------------------------------------------
module tb_phase_measure;
   import phase_measure_pkg::*;

   localparam int MID     = 2048;
   localparam int HYST    = 64;
   localparam int TIMEOUT = 1023;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        inValid = 1'b0;
   logic [11:0] refIn = '0;
   logic [11:0] shfIn = '0;
   logic [7:0]  oPhase;
   logic [9:0]  oDelay;
   logic [9:0]  oPeriod;
   logic        oPhaseValid;
   logic        oPeriodValid;
   logic        oTimeout;

   int checks = 0;
   int failures = 0;
   int sineTab[256];
   int sPos = 0;
   int toSeen = 0;

   // behavioural model state
   int refWin[$];
   int shfWin[$];
   int refPrev, shfPrev, vIdx, measRef, perRef;
   bit measuring, perRun, perSat;
   int eDelay, ePeriod;
   bit ePv, ePerv, eTo;

   typedef struct {
      bit v; int r; int s;
      bit pv; int d; bit perv; int p; bit to;
   } vec_t;
   vec_t tbl[13];

   always #5 clk = ~clk;

   phase_measure dut (
      .i_clk          (clk),
      .i_rst_n        (rstN),
      .i_in_valid     (inValid),
      .i_ref_in       (refIn),
      .i_shf_in       (shfIn),
      .o_phase        (oPhase),
      .o_delay        (oDelay),
      .o_period       (oPeriod),
      .o_phase_valid  (oPhaseValid),
      .o_period_valid (oPeriodValid),
      .o_timeout      (oTimeout)
   );

   // A crossing: previous sample below MID, current at/above MID, and some
   // sample since the last crossing (or reset) went below MID-HYST.
   function automatic bit seesCrossing(input int win[$], input int prev, input int s);
      bit lowSeen = 1'b0;
      foreach (win[i]) if (win[i] < MID - HYST) lowSeen = 1'b1;
      return lowSeen && (prev < MID) && (s >= MID);
   endfunction

   task automatic modelReset();
      refWin.delete(); shfWin.delete();
      refPrev = 0; shfPrev = 0; vIdx = 0; measRef = 0; perRef = 0;
      measuring = 0; perRun = 0; perSat = 0;
      eDelay = 0; ePeriod = 0; ePv = 0; ePerv = 0; eTo = 0;
   endtask

   // Events are expressed as distances between valid-sample indices.
   task automatic modelStep(input bit v, input int r, input int s);
      bit rx, sx;
      ePv = 0; ePerv = 0; eTo = 0;
      if (!v) return;
      rx = seesCrossing(refWin, refPrev, r);
      sx = seesCrossing(shfWin, shfPrev, s);
      refWin.push_back(r); if (rx) refWin.delete();
      shfWin.push_back(s); if (sx) shfWin.delete();
      refPrev = r; shfPrev = s;
      if (measuring) begin
         if (sx) begin
            eDelay = vIdx - measRef; ePv = 1;
            measuring = rx; measRef = vIdx;
         end else if (rx) begin
            measRef = vIdx;
         end else if (vIdx - measRef == TIMEOUT) begin
            eTo = 1; measuring = 0;
         end
      end else if (rx) begin
         if (sx) begin
            eDelay = 0; ePv = 1;
         end else begin
            measuring = 1; measRef = vIdx;
         end
      end
      if (rx) begin
         if (perRun && !perSat) begin
            ePeriod = vIdx - perRef; ePerv = 1;
         end
         perRun = 1; perSat = 0; perRef = vIdx;
      end else if (perRun && !perSat && (vIdx - perRef == TIMEOUT)) begin
         eTo = 1; perSat = 1;
      end
      vIdx++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      if (oTimeout) toSeen++;
      check("phase_valid", int'(oPhaseValid), int'(ePv));
      check("period_valid", int'(oPeriodValid), int'(ePerv));
      check("timeout", int'(oTimeout), int'(eTo));
      check("delay", int'(oDelay), eDelay);
      check("phase", int'(oPhase), eDelay % 256);
      check("period", int'(oPeriod), ePeriod);
   endtask

   task automatic applyStimulus(input bit v, input int r, input int s);
      inValid = v; refIn = 12'(r); shfIn = 12'(s);
      @(posedge clk); #1;
      modelStep(v, r, s);
      checkOutput();
   endtask

   task automatic applyReset();
      rstN = 1'b0; inValid = 1'b1;
      refIn = 12'($urandom_range(0, 4095)); shfIn = 12'($urandom_range(0, 4095));
      @(posedge clk); #1;
      modelReset();
      checkOutput();
      rstN = 1'b1;
   endtask

   // mode 0: always valid, 1: toggle every clock, 2: random ~70% valid.
   // Invalid clocks carry garbage samples.
   task automatic runSine(input int n, input int lag, input int mode, input int noise);
      int r, s;
      bit v;
      for (int i = 0; i < n; i++) begin
         v = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : ($urandom_range(0, 99) < 70);
         if (v) begin
            r = sineTab[sPos % 256];
            if (noise > 0) r = r + int'($urandom_range(0, 2 * noise)) - noise;
            if (r < 0) r = 0;
            if (r > 4095) r = 4095;
            s = sineTab[(((sPos - lag) % 256) + 256) % 256];
            sPos++;
         end else begin
            r = int'($urandom_range(0, 4095));
            s = int'($urandom_range(0, 4095));
         end
         applyStimulus(v, r, s);
      end
   endtask

   initial begin
      int toAt, toBefore, startTo;
      for (int i = 0; i < 256; i++)
         sineTab[i] = 2048 + $rtoi($floor(2047.0 * $sin(2.0 * 3.14159265358979 * i / 256.0) + 0.5));

      tbl[0]  = '{1, 3000, 3000, 0, 0, 0, 0, 0};
      tbl[1]  = '{1,  100,  100, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 2047,  100, 0, 0, 0, 0, 0};
      tbl[3]  = '{1, 2048,  100, 0, 0, 0, 0, 0};
      tbl[4]  = '{1, 2000, 1990, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 2100, 2048, 0, 0, 0, 0, 0};
      tbl[6]  = '{1, 2100, 2048, 1, 2, 0, 0, 0};
      tbl[7]  = '{1, 1983, 1983, 0, 2, 0, 0, 0};
      tbl[8]  = '{1, 2048, 2048, 1, 0, 1, 4, 0};
      tbl[9]  = '{1, 1000, 1000, 0, 0, 0, 4, 0};
      tbl[10] = '{1, 2500, 1500, 0, 0, 1, 2, 0};
      tbl[11] = '{1, 1000, 1500, 0, 0, 0, 2, 0};
      tbl[12] = '{1, 3000, 3000, 1, 2, 1, 2, 0};

      modelReset();
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      applyReset();

      // directed corner vectors
      for (int i = 0; i < 13; i++) begin
         inValid = tbl[i].v; refIn = 12'(tbl[i].r); shfIn = 12'(tbl[i].s);
         @(posedge clk); #1;
         modelStep(tbl[i].v, tbl[i].r, tbl[i].s);
         check($sformatf("tbl%0d_phase_valid", i), int'(oPhaseValid), int'(tbl[i].pv));
         check($sformatf("tbl%0d_delay", i), int'(oDelay), tbl[i].d);
         check($sformatf("tbl%0d_phase", i), int'(oPhase), tbl[i].d % 256);
         check($sformatf("tbl%0d_period_valid", i), int'(oPeriodValid), int'(tbl[i].perv));
         check($sformatf("tbl%0d_period", i), int'(oPeriod), tbl[i].p);
         check($sformatf("tbl%0d_timeout", i), int'(oTimeout), int'(tbl[i].to));
      end

      // lag 64, continuous valid
      applyReset();
      runSine(900, 64, 0, 0);
      check("lag64_phase", int'(oPhase), 64);
      check("lag64_period", int'(oPeriod), 256);

      // lag 0, identical streams, no timeout expected
      toBefore = toSeen;
      runSine(700, 0, 0, 0);
      check("lag0_phase", int'(oPhase), 0);
      check("lag0_no_timeout", toSeen - toBefore, 0);

      // lag switch 64 -> 128 mid-run
      runSine(400, 64, 0, 0);
      runSine(800, 128, 0, 0);
      check("lag128_phase", int'(oPhase), 128);
      check("lag128_delay", int'(oDelay), 128);

      // shf stuck at 0 after one ref crossing: timeout 1023 samples later
      applyStimulus(1, 100, 0);
      applyStimulus(1, 3000, 0);
      toAt = -1; startTo = toSeen;
      for (int i = 1; i <= 1100; i++) begin
         applyStimulus(1, 3000, 0);
         if (oTimeout && toAt < 0) toAt = i;
      end
      check("timeout_latency", toAt, 1023);
      check("timeout_pulse_count", toSeen - startTo, 1);
      check("timeout_delay_hold", int'(oDelay), 128);

      // in_valid toggling with lag 64
      applyReset();
      runSine(1600, 64, 1, 0);
      check("toggle_phase", int'(oPhase), 64);
      check("toggle_period", int'(oPeriod), 256);

      // reset mid-measurement
      runSine(300, 64, 0, 0);
      for (int i = 0; i < 600 && !(measuring && (vIdx - measRef == 20)); i++)
         runSine(1, 64, 0, 0);
      check("reached_count_state", int'(measuring), 1);
      applyReset();
      check("reset_phase", int'(oPhase), 0);
      check("reset_delay", int'(oDelay), 0);
      check("reset_period", int'(oPeriod), 0);
      check("reset_pulses", int'({oPhaseValid, oPeriodValid, oTimeout}), 0);
      runSine(600, 64, 0, 0);
      check("post_reset_phase", int'(oPhase), 64);

      // noisy reference dithering around mid-scale
      runSine(900, 64, 0, 10);

      // randomized lags and valid patterns
      for (int t = 0; t < 3; t++) begin
         applyReset();
         runSine(1100, int'($urandom_range(0, 200)), 2, int'($urandom_range(0, 10)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
